// File: rtl/seq_player.sv
// rtl/seq_player.sv - LED color sequence player driven from an external sequence store
//
// Purpose: plays `length` color elements read from an external store.
// Each element is a 1-cycle LOAD, an ON period scaled by speed, and a dark GAP.
//
// Ports:
//   clock     - single clock, rising edge
//   reset     - asynchronous active-high reset
//   play      - start request, ignored while busy
//   abort     - cancel playback in progress; done is not pulsed
//   length    - element count; 17..31 clamp to 16, 0 completes immediately
//   speed     - on-time select: on_len = ON_CYCLES >> min(speed, 2)
//   seq_data  - color code returned by the store for seq_addr
//   seq_addr  - registered element index
//   leds      - one-hot color drive (code 3 lights nothing)
//   busy      - high in every state except IDLE
//   done      - one-cycle pulse on normal completion
module seq_player #(
  parameter int ON_CYCLES  = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       abort,
  input  logic [4:0] length,
  input  logic [1:0] speed,
  input  logic [1:0] seq_data,
  output logic [3:0] seq_addr,
  output logic [2:0] leds,
  output logic       busy,
  output logic       done
);

  localparam int CW = 16;
  localparam logic [CW-1:0] ON0_LAST = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] ON1_LAST = CW'((ON_CYCLES >> 1) - 1);
  localparam logic [CW-1:0] ON2_LAST = CW'((ON_CYCLES >> 2) - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ON,
    S_GAP,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      idx_q, idx_d;
  logic [4:0]      len_q, len_d;
  logic [1:0]      spd_q, spd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      leds_q, leds_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [4:0]      len_clamp;
  logic [CW-1:0]   on_last;
  logic [2:0]      color_onehot;

  always_comb begin
    len_clamp = (length > 5'd16) ? 5'd16 : length;

    // speed 3 deliberately shares the speed-2 on-time
    case (spd_q)
      2'd0:    on_last = ON0_LAST;
      2'd1:    on_last = ON1_LAST;
      default: on_last = ON2_LAST;
    endcase

    // code 3 still occupies a full timed slot, just with all LEDs dark
    case (seq_data)
      2'd0:    color_onehot = 3'b001;
      2'd1:    color_onehot = 3'b010;
      2'd2:    color_onehot = 3'b100;
      default: color_onehot = 3'b000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    spd_d   = spd_q;
    cnt_d   = cnt_q;
    leds_d  = leds_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort outranks play, so a simultaneous pair leaves us idle
        if (play && !abort) begin
          busy_d = 1'b1;
          if (len_clamp == 5'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            len_d   = len_clamp;
            spd_d   = speed;
            idx_d   = 4'd0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        leds_d  = color_onehot;
        cnt_d   = on_last;
        state_d = S_ON;
      end
      S_ON: begin
        if (cnt_q == '0) begin
          leds_d  = 3'b000;
          cnt_d   = GAP_LAST;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (({1'b0, idx_q} + 5'd1) < len_q) begin
            idx_d   = idx_q + 4'd1;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        leds_d  = 3'b000;
      end
    endcase

    // abort overrides whatever the state logic chose, including a pending done
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
      cnt_d   = '0;
      leds_d  = 3'b000;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      len_q   <= 5'd0;
      spd_q   <= 2'd0;
      cnt_q   <= '0;
      leds_q  <= 3'b000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      spd_q   <= spd_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign seq_addr = idx_q;
  assign leds     = leds_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_seq_player.sv
// tb/tb_seq_player.sv - directed self-checking bench for seq_player
module tb_seq_player;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       play  = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] length = 5'd0;
  logic [1:0] speed  = 2'd0;
  logic [1:0] seq_data;
  logic [3:0] seq_addr;
  logic [2:0] leds;
  logic       busy;
  logic       done;

  logic [1:0] mem [16];

  int checks = 0;
  int errors = 0;

  seq_player #(.ON_CYCLES(8), .GAP_CYCLES(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .play     (play),
    .abort    (abort),
    .length   (length),
    .speed    (speed),
    .seq_data (seq_data),
    .seq_addr (seq_addr),
    .leds     (leds),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  assign seq_data = mem[seq_addr];

  function automatic logic [2:0] color_led(input logic [1:0] c);
    case (c)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_play(input logic [4:0] len, input logic [1:0] spd);
    length = len;
    speed  = spd;
    play   = 1'b1;
    tick();
    play = 1'b0;
    check("busy after play", 32'(busy), 32'd1);
  endtask

  // Element period is 1 + on_len + 4; after edge k the element index is k/P
  // and the LEDs are lit for the first on_len cycles of each period.
  // dk > 0 re-pulses play with altered length/speed while busy.
  task automatic run_check(input int L, input int on_len, input int dk);
    int p;
    int t;
    int e;
    int r;
    int ea;
    logic [2:0] el;
    p = 1 + on_len + 4;
    for (int k = 1; k <= L * p + 1; k++) begin
      tick();
      if (k == dk + 1) play = 1'b0;
      t = k - 1;
      e = t / p;
      r = t % p;
      el = 3'b000;
      if (k <= L * p && r < on_len) el = color_led(mem[e]);
      check($sformatf("leds k=%0d", k), 32'(leds), 32'(el));
      check($sformatf("busy k=%0d", k), 32'(busy), (k <= L * p) ? 32'd1 : 32'd0);
      check($sformatf("done k=%0d", k), 32'(done), (k == L * p) ? 32'd1 : 32'd0);
      if (k <= L * p) begin
        ea = k / p;
        if (ea > L - 1) ea = L - 1;
        check($sformatf("seq_addr k=%0d", k), 32'(seq_addr), 32'(ea));
      end
      if (k == dk) begin
        play   = 1'b1;
        length = 5'd5;
        speed  = 2'd3;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);

    // async reset before any clock edge
    #2 reset = 1'b1;
    #2;
    check("reset leds", 32'(leds), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset seq_addr", 32'(seq_addr), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // nominal 3-element playback, play accepted on first edge after release
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2;
    start_play(5'd3, 2'd0);
    check("nominal leds at E0", 32'(leds), 32'd0);
    run_check(3, 8, 0);

    // speed scaling with invalid color
    mem[0] = 2'd3;
    start_play(5'd1, 2'd2);
    run_check(1, 2, 0);
    start_play(5'd1, 2'd3);
    run_check(1, 2, 0);

    // length 0 completes immediately with no LED activity
    start_play(5'd0, 2'd0);
    check("len0 done", 32'(done), 32'd1);
    check("len0 leds", 32'(leds), 32'd0);
    tick();
    check("len0 done low", 32'(done), 32'd0);
    check("len0 busy low", 32'(busy), 32'd0);

    // length 20 clamps to 16, addresses 0..15, speed 1
    for (int i = 0; i < 16; i++) mem[i] = 2'((i + 1) % 4);
    start_play(5'd20, 2'd1);
    run_check(16, 4, 0);

    // play re-pulsed mid-sequence with changed length/speed
    mem[0] = 2'd2; mem[1] = 2'd0;
    start_play(5'd2, 2'd0);
    run_check(2, 8, 5);

    // abort during second element's ON
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2;
    start_play(5'd3, 2'd0);
    for (int k = 1; k <= 16; k++) tick();
    check("abort pre leds", 32'(leds), 32'b010);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort leds", 32'(leds), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort seq_addr", 32'(seq_addr), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post-abort done", 32'(done), 32'd0);
      check("post-abort busy", 32'(busy), 32'd0);
    end
    start_play(5'd1, 2'd0);
    run_check(1, 8, 0);

    // play with abort in IDLE stays idle
    play  = 1'b1;
    abort = 1'b1;
    tick();
    play  = 1'b0;
    abort = 1'b0;
    check("play+abort busy", 32'(busy), 32'd0);
    check("play+abort done", 32'(done), 32'd0);

    // async reset between edges during the second element's GAP
    start_play(5'd2, 2'd0);
    for (int k = 1; k <= 23; k++) tick();
    check("gap seq_addr", 32'(seq_addr), 32'd1);
    check("gap busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid reset leds", 32'(leds), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset done", 32'(done), 32'd0);
    check("mid reset seq_addr", 32'(seq_addr), 32'd0);
    #1 reset = 1'b0;
    start_play(5'd2, 2'd0);
    run_check(2, 8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_player.md
SEQ_PLAYER -- requirements
Module: seq_player

Interface
REQ-001 The block SHALL have parameter ON_CYCLES, default 8: LED on-time in clock cycles at speed 0; multiple of 4, minimum 4.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 4: LED dark gap after each element, in clock cycles; minimum 1.
REQ-003 The block SHALL have port clock, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port play, input, 1 bit: request to start playback, sampled on the rising edge.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel playback in progress.
REQ-007 The block SHALL have port length, input, 5 bits: number of sequence elements to play; values 17-31 are clamped to 16.
REQ-008 The block SHALL have port speed, input, 2 bits: on-time select.
REQ-009 The block SHALL have port seq_data, input, 2 bits: color code returned by the external sequence store for seq_addr, combinational read.
REQ-010 The block SHALL have port seq_addr, output, 4 bits: registered element index presented to the sequence store.
REQ-011 The block SHALL have port leds, output, 3 bits: one-hot color drive, with bit n lit for color n (pairs with btn[2:0]).
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on normal completion.

Function
REQ-014 The block SHALL implement the FSM states IDLE, LOAD, ON, GAP and DONE, with all outputs registered.
REQ-015 In IDLE, a sampled play=1 with clamped length L>=1 SHALL latch L and speed, set idx=0, and move to LOAD.
REQ-016 In IDLE, a sampled play=1 with length=0 SHALL move directly to DONE, with no LED activity.
REQ-017 LOAD SHALL last 1 cycle; on its exit edge, leds SHALL load the one-hot of seq_data (00->001, 01->010, 10->100, 11->000 with the slot still timed) and the FSM SHALL move to ON.
REQ-018 ON SHALL last on_len cycles, where on_len = ON_CYCLES >> min(latched speed, 2) (speed 3 behaves as speed 2); leds SHALL be held constant throughout.
REQ-019 On ON exit, leds SHALL be set to 000 and the FSM SHALL move to GAP, which lasts GAP_CYCLES cycles.
REQ-020 On GAP exit, if idx+1 < L then idx SHALL increment and the FSM SHALL move to LOAD; otherwise it SHALL move to DONE.
REQ-021 Each element SHALL occupy exactly 1 + on_len + GAP_CYCLES cycles.
REQ-022 seq_addr SHALL equal idx at all times; idx is 4 bits and never wraps, because L<=16 limits idx to 15.
REQ-023 DONE SHALL last 1 cycle with done=1, then the FSM SHALL return to IDLE.
REQ-024 busy SHALL be 1 in LOAD, ON, GAP and DONE.
REQ-025 play asserted while busy=1 SHALL be ignored, with no restart and no queuing.
REQ-026 Changes on length or speed while busy SHALL have no effect on the playback in progress.
REQ-027 A sampled abort=1 in any non-IDLE state SHALL, on the next edge, force IDLE with leds=000 and idx=0, and SHALL NOT pulse done.
REQ-028 abort has priority over play; abort in IDLE SHALL have no effect.
REQ-029 Simultaneous play=1 and abort=1 in IDLE SHALL leave the block in IDLE.

Reset
REQ-030 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, idx=0, seq_addr=0, leds=000, busy=0, done=0, and clear all counters and latched length/speed.
REQ-031 A reset asserted mid-playback SHALL abandon the playback with no done pulse.
REQ-032 After reset release, the block SHALL accept play on the first rising edge.

Verification
REQ-033 Scenario, nominal 3-element playback: ON_CYCLES=8, GAP_CYCLES=4, speed=0, length=3, store {0,1,2}, play sampled at edge E0 -> leds=001 from E1 to E9, 010 from E14 to E22, 100 from E27 to E35; done=1 for the cycle after E39; busy falls at E40.
REQ-034 Scenario, speed scaling and invalid color: speed=2 (and separately 3), length=1, seq_data=11 -> leds stay 000 for all 1+2+4 cycles; done follows 7 cycles after play.
REQ-035 Scenario, length boundaries: length=0 -> done pulses 1 cycle after play with no LED activity; length=20 -> exactly 16 elements play, seq_addr runs 0..15 and does not wrap.
REQ-036 Scenario, abort: abort asserted during the second element's ON -> next edge gives leds=000, busy=0, no done pulse; a new play is then accepted normally.
REQ-037 Scenario, play while busy: play re-pulsed mid-sequence, with length/speed changed -> original playback timing and element count are unchanged.
REQ-038 Scenario, asynchronous reset: reset asserted between clock edges during GAP -> outputs reach reset values before the next edge; play after release starts from idx 0.
